// File: rtl/booth_mul_sched.sv
// rtl/booth_mul_sched.sv - round-robin shared sequential radix-2 Booth multiplier
module booth_mul_sched #(
    parameter int WIDTH = 6,
    parameter int NREQ  = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_mcand,
    input  logic [NREQ*WIDTH-1:0]   req_mplier,
    output logic [NREQ-1:0]         req_ready,
    output logic                    resp_valid,
    output logic [IDW-1:0]          resp_id,
    output logic [2*WIDTH-1:0]      resp_product,
    input  logic                    resp_ready,
    output logic                    busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STEP,
        S_DONE
    } state_t;

    state_t                 state;
    logic [IDW-1:0]         ptr;
    logic [IDW-1:0]         id;
    logic [IDW-1:0]         grant_idx;
    logic                   grant_found;
    logic [IDW-1:0]         cand;
    int                     cand_int;
    logic [WIDTH-1:0]       mc_sel;
    logic [WIDTH-1:0]       mp_sel;

    // A and M carry one guard bit so that -M of the most negative operand is exact.
    logic signed [WIDTH:0]  a;
    logic signed [WIDTH:0]  m;
    logic signed [WIDTH:0]  a_sum;
    logic [WIDTH-1:0]       q;
    logic                   q_prev;
    logic [CW-1:0]          cnt;

    // First requesting index at or above ptr, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        cand_int    = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand_int = int'(ptr) + i;
            if (cand_int >= NREQ) begin
                cand_int = cand_int - NREQ;
            end
            cand = IDW'(cand_int);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && (state == S_IDLE) && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign mc_sel = req_mcand[grant_idx*WIDTH +: WIDTH];
    assign mp_sel = req_mplier[grant_idx*WIDTH +: WIDTH];

    always_comb begin
        case ({q[0], q_prev})
            2'b10:   a_sum = a - m;
            2'b01:   a_sum = a + m;
            default: a_sum = a;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            ptr        <= '0;
            id         <= '0;
            a          <= '0;
            m          <= '0;
            q          <= '0;
            q_prev     <= 1'b0;
            cnt        <= '0;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        m      <= {mc_sel[WIDTH-1], mc_sel};
                        a      <= '0;
                        q      <= mp_sel;
                        q_prev <= 1'b0;
                        cnt    <= '0;
                        id     <= grant_idx;
                        ptr    <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                        busy   <= 1'b1;
                        state  <= S_STEP;
                    end
                end
                S_STEP: begin
                    // Arithmetic right shift of {A,Q,q_prev}; the sign of the new A is replicated.
                    a      <= {a_sum[WIDTH], a_sum[WIDTH:1]};
                    q      <= {a_sum[0], q[WIDTH-1:1]};
                    q_prev <= q[0];
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        resp_valid <= 1'b1;
                        state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign resp_id      = id;
    assign resp_product = {a[WIDTH-1:0], q};

endmodule

// File: tb/tb_booth_mul_sched.sv
// tb/tb_booth_mul_sched.sv - scoreboard testbench for booth_mul_sched
module tb_booth_mul_sched;

    localparam int W   = 6;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N-1:0]       req_valid;
    logic [N*W-1:0]     req_mcand;
    logic [N*W-1:0]     req_mplier;
    logic [N-1:0]       req_ready;
    logic               resp_valid;
    logic [IDW-1:0]     resp_id;
    logic [2*W-1:0]     resp_product;
    logic               resp_ready;
    logic               busy;

    always #5 clk = ~clk;

    booth_mul_sched #(.WIDTH(W), .NREQ(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_mcand    (req_mcand),
        .req_mplier   (req_mplier),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_id      (resp_id),
        .resp_product (resp_product),
        .resp_ready   (resp_ready),
        .busy         (busy)
    );

    typedef struct {
        int             id;
        logic [2*W-1:0] prod;
        int             edge_k;
    } exp_t;

    exp_t           sb[$];
    logic [2*W-1:0] pend[N][$];
    logic [W-1:0]   mcv[N];
    logic [W-1:0]   mpv[N];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ptr_m  = 0;
    int gidx   = 0;
    int acc_id = -1;
    bit model_idle = 1'b1;
    bit gflag      = 1'b0;
    bit rand_ready = 1'b0;
    bit prev_hold  = 1'b0;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_mcand[i*W +: W]  = mcv[i];
            req_mplier[i*W +: W] = mpv[i];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [2*W-1:0] ref_mul(logic [W-1:0] x, logic [W-1:0] y);
        int p;
        p = int'($signed(x)) * int'($signed(y));
        return p[2*W-1:0];
    endfunction

    function automatic void drive();
        for (int i = 0; i < N; i++) begin
            if (pend[i].size() > 0) begin
                req_valid[i]     = 1'b1;
                {mcv[i], mpv[i]} = pend[i][0];
            end else begin
                req_valid[i] = 1'b0;
            end
        end
    endfunction

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) begin
            if (pend[i].size() > 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Grant observer: predicts the round-robin winner and records the expected response.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            ptr_m      = 0;
            model_idle = 1'b1;
            gflag      = 1'b0;
            chk("ready_in_reset", int'(req_ready), 0);
        end else begin : obs
            int           g;
            int           j;
            logic [N-1:0] exp_ready;
            chk("busy", int'(busy), model_idle ? 0 : 1);
            g         = -1;
            exp_ready = '0;
            if (model_idle) begin
                for (int i = 0; i < N; i++) begin
                    j = (ptr_m + i) % N;
                    if (g < 0 && req_valid[j]) g = j;
                end
            end
            if (g >= 0) exp_ready[g] = 1'b1;
            chk("req_ready", int'(req_ready), int'(exp_ready));
            if (g >= 0) begin
                sb.push_back('{g, ref_mul(mcv[g], mpv[g]), cyc + 1});
                ptr_m      = (g + 1) % N;
                model_idle = 1'b0;
                gflag      = 1'b1;
                gidx       = g;
            end
            if (resp_valid && resp_ready) model_idle = 1'b1;
        end
    end

    // Response monitor: compares every presented product against the scoreboard head.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_unexpected actual id=%0d product=%0h required no response",
                             resp_id, resp_product);
                end else begin
                    if (!prev_hold) chk("resp_latency", cyc - sb[0].edge_k, W);
                    chk("resp_id", int'(resp_id), sb[0].id);
                    chk("resp_product", int'(resp_product), int'(sb[0].prod));
                    if (resp_ready) void'(sb.pop_front());
                end
            end
            prev_hold = resp_valid && !resp_ready;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        acc_id = -1;
        if (gflag) begin
            acc_id = gidx;
            void'(pend[gidx].pop_front());
            gflag = 1'b0;
        end
        if (rand_ready) resp_ready = ($urandom_range(0, 3) != 0);
        drive();
    endtask

    task automatic wait_drain(int bound);
        int n;
        n = 0;
        while (!(all_empty() && sb.size() == 0 && model_idle) && n < bound) begin
            step();
            n++;
        end
        if (!(all_empty() && sb.size() == 0 && model_idle)) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual pending=%0d required 0 within %0d cycles", sb.size(), bound);
        end
    endtask

    initial begin
        int n;
        rst_n      = 1'b0;
        resp_ready = 1'b0;
        req_valid  = '0;
        for (int i = 0; i < N; i++) begin
            mcv[i] = '0;
            mpv[i] = '0;
        end
        pend[1].push_back({6'd3, 6'd5});
        drive();
        repeat (3) step();
        chk("rst_resp_valid", int'(resp_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_resp_id", int'(resp_id), 0);
        chk("rst_resp_product", int'(resp_product), 0);
        chk("rst_req_ready", int'(req_ready), 0);
        rst_n      = 1'b1;
        resp_ready = 1'b1;
        wait_drain(100);

        pend[0].push_back({6'd7, 6'h3D});
        drive();
        wait_drain(100);

        pend[1].push_back({6'h20, 6'h20});
        pend[1].push_back({6'h20, 6'd31});
        pend[1].push_back({6'd31, 6'd31});
        pend[1].push_back({6'd0, 6'h20});
        drive();
        wait_drain(200);

        pend[2].push_back({6'd5, 6'h3B});
        drive();
        acc_id = -1;
        n = 0;
        while (acc_id != 2 && n < 20) begin
            step();
            n++;
        end
        chk("reset_test_accept", acc_id, 2);
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midop_reset_busy", int'(busy), 0);
        chk("midop_reset_resp_valid", int'(resp_valid), 0);
        pend[3].push_back({6'd9, 6'd2});
        pend[1].push_back({6'h31, 6'd4});
        drive();
        wait_drain(200);

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N; i++) begin
                pend[i].push_back({6'(i * 11 + k * 5 + 1), 6'($urandom)});
            end
        end
        drive();
        wait_drain(400);

        resp_ready = 1'b0;
        pend[3].push_back({6'h2B, 6'h17});
        drive();
        n = 0;
        while (!resp_valid && n < 40) begin
            step();
            n++;
        end
        chk("bp_resp_valid", int'(resp_valid), 1);
        pend[0].push_back({6'd12, 6'h3F});
        drive();
        repeat (20) step();
        resp_ready = 1'b1;
        wait_drain(100);

        rand_ready = 1'b1;
        for (int i = 0; i < 80; i++) begin
            pend[$urandom_range(0, N - 1)].push_back(12'($urandom));
        end
        drive();
        wait_drain(3000);
        rand_ready = 1'b0;
        resp_ready = 1'b1;

        for (int x = 0; x < 64; x++) begin
            for (int y = 0; y < 64; y++) begin
                pend[2].push_back({6'(x), 6'(y)});
            end
        end
        drive();
        wait_drain(4096 * (W + 2) + 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/booth_mul_sched.md
# booth_mul_sched

Sequential radix-2 Booth multiply engine with a round-robin scheduler that shares it among NREQ requesters. It performs one Booth add/shift step per clock instead of unrolling all steps combinationally. It sits between several producers of signed operand pairs and their consumers, returning the product tagged with the requester index.

## Interface
- WIDTH, 6: operand width in bits; the product is 2*WIDTH bits.
- NREQ, 4: number of requesters (minimum 2). IDW = clog2(NREQ).
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  synchronous, active-low reset. Sampled on the clk rising edge.
- req_valid  in  NREQ  per-requester request valid.
- req_mcand  in  NREQ*WIDTH  signed multiplicands; requester i uses bits [i*WIDTH +: WIDTH].
- req_mplier  in  NREQ*WIDTH  signed multipliers; same packing as req_mcand.
- req_ready  out  NREQ  one-hot accept; combinational from state, pointer and req_valid.
- resp_valid  out  1  product available.
- resp_id  out  IDW  index of the requester that owns the product.
- resp_product  out  2*WIDTH  signed product.
- resp_ready  in  1  consumer accepts the product.
- busy  out  1  high in any state other than IDLE.

## Operation
- The FSM has three states: IDLE, STEP, DONE. Reset state is IDLE.
- **IDLE**
  - If any req_valid bit is set, the scheduler grants index g: the first set bit searching upward from ptr, wrapping modulo NREQ.
  - req_ready[g]=1 and all other req_ready bits are 0. No other state asserts req_ready.
  - On that edge the engine captures:
    - M = sign-extended req_mcand[g]
    - A = 0
    - Q = req_mplier[g]
    - q_prev = 0
    - cnt = 0
    - id = g
    - ptr = (g+1) mod NREQ
  - The state moves to STEP.
- **STEP** (one Booth step per cycle)
  - If {Q[0],q_prev}=10, then A=A-M. If 01, then A=A+M. If 00 or 11, A is unchanged.
  - Then {A,Q,q_prev} is arithmetically shifted right by 1, replicating the sign of A.
  - cnt increments. When the step with cnt==WIDTH-1 completes, the state moves to DONE.
- **Width rule**
  - A and M are WIDTH+1 bits wide internally, so -M never overflows. This keeps -2^(WIDTH-1) operands exact.
  - resp_product = {A[WIDTH-1:0],Q}, which equals the exact two's-complement product for every operand pair.
- **DONE**
  - resp_valid=1; resp_product and resp_id are stable.
  - When resp_valid & resp_ready, the state moves to IDLE.
  - Without resp_ready the state holds indefinitely (backpressure). No new request is accepted while in DONE.
- **Reset mid-operation** (STEP or DONE)
  - The operation is discarded: no response, state=IDLE, ptr=0.
- Requesters must hold req_valid and operands stable until their req_ready. Operands are sampled only on the accept edge, so later changes have no effect.
- Reset values:
  - req_ready=0 (during reset)
  - resp_valid=0
  - resp_id=0
  - resp_product=0
  - busy=0
  - ptr=0
  - cnt=0

## Timing
- Accept handshake at edge k. Steps execute at edges k+1..k+WIDTH.
- resp_valid rises after edge k+WIDTH and is first sampleable at edge k+WIDTH+1 (k+7 for WIDTH=6).
- If resp_ready is held high: response handshake at k+WIDTH+1, IDLE afterwards, next accept at the earliest edge k+WIDTH+2. Peak throughput is one product per WIDTH+2 cycles.
- req_ready has a combinational path from req_valid. No input-to-output path exists through the datapath.
- Simultaneous requests are served strictly round-robin. A continuously requesting index waits at most NREQ-1 operations.

## Test plan
- Single op: requester 0, mcand=7, mplier=-3, resp_ready=1 -> req_ready[0] at edge 0; resp_valid at edge 7; product 12'hFEB (-21); resp_id=0.
- Corner operands:
  - -32 * -32 -> 12'h400 (1024)
  - -32 * 31 -> 12'hC20 (-992)
  - 31 * 31 -> 12'h3C1 (961)
  - 0 * -32 -> 12'h000
- Contention: all four req_valid held high with distinct operands -> grants in order 0,1,2,3,0. Each resp_id matches its product. Exactly one req_ready bit per accept.
- Backpressure: resp_ready=0 for 20 cycles after resp_valid -> resp_valid, resp_id and resp_product held constant; busy=1; no req_ready. Releasing resp_ready gives the handshake, then IDLE.
- Reset during STEP (rst_n low at edge k+3) -> next cycle busy=0 and resp_valid=0. No response appears; the next grant goes to the lowest requesting index (ptr=0).
- Exhaustive: all 4096 operand pairs through requester 2 -> every product matches a signed reference multiply.
